// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence-detector controller.
// A pattern (1..PAT_W bits) is configured over a valid/ready handshake, a run is opened
// with start and closed with stop, and every pattern match on the serial x stream gives
// a one-cycle z pulse and advances a saturating match counter.
// Optional feature: define SEQ_DET_TIMEOUT_EN to end a run after TMO_CYC consecutive
// cycles without x_valid (timeout pulse). Undefined: timeout is tied low.
module seq_det_ctrl #(
    parameter int unsigned PAT_W   = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TMO_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    input  logic             x_valid,
    input  logic             x,
    output logic             z,
    output logic             busy,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             timeout
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

    localparam logic [LEN_W:0]   PatWMax = (LEN_W + 1)'(PAT_W);
    localparam logic [LEN_W-1:0] FillMax = LEN_W'(PAT_W);

    state_e             state_q;
    logic [PAT_W-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [PAT_W-1:0]   hist_q;
    logic [LEN_W-1:0]   fill_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sat_q;
    logic               z_q;
    logic               err_q;

    logic               cfg_legal;
    logic [PAT_W-1:0]   hist_d;
    logic [LEN_W-1:0]   fill_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [PAT_W-1:0]   len_mask;
    logic               match;

`ifdef SEQ_DET_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               tmo_q;
`else
    logic               unused_tmo;
    assign unused_tmo = (TMO_CYC == 0);
`endif

    // Config legality and next history/fill/count values for a sample taken this cycle.
    always_comb begin
        cfg_legal = (cfg_len != '0) && ({1'b0, cfg_len} <= PatWMax);
        hist_d    = {hist_q[PAT_W-2:0], x};
        fill_d    = (fill_q == FillMax) ? fill_q : fill_q + LEN_W'(1);
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        len_mask  = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        // Only the newest len bits are compared; older history is masked off.
        match = (fill_d >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);
    end

    // Control FSM with all state and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            z_q   <= 1'b0;
            err_q <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            unique case (state_q)
                StIdle, StArmed: begin
                    // A config transfer in the same cycle as start takes precedence.
                    if (cfg_valid) begin
                        if (cfg_legal) begin
                            pat_q   <= cfg_pattern;
                            len_q   <= cfg_len;
                            ovl_q   <= cfg_overlap;
                            cnt_q   <= '0;
                            sat_q   <= 1'b0;
                            state_q <= StArmed;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (start && (state_q == StArmed)) begin
                        hist_q  <= '0;
                        fill_q  <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        state_q <= StRun;
`ifdef SEQ_DET_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                    end
                end
                StRun: begin
                    // stop wins over a coincident sample, which is dropped.
                    if (stop) begin
                        state_q <= StArmed;
                    end else if (x_valid) begin
                        hist_q <= hist_d;
`ifdef SEQ_DET_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                        if (match) begin
                            z_q    <= 1'b1;
                            cnt_q  <= cnt_d;
                            sat_q  <= sat_q | (cnt_d == '1);
                            fill_q <= ovl_q ? fill_d : '0;
                        end else begin
                            fill_q <= fill_d;
                        end
                    end
`ifdef SEQ_DET_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                        tmo_q     <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= StArmed;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg_ready = (state_q != StRun);
    assign busy      = (state_q == StRun);
    assign z         = z_q;
    assign cfg_err   = err_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;
`ifdef SEQ_DET_TIMEOUT_EN
    assign timeout   = tmo_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: directed scenarios plus randomized traffic, all checked every
// cycle against a queue-based reference model of the detector.
module tb_seq_det_ctrl;

    localparam int unsigned PAT_W   = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned TMO_CYC = 8;
    localparam int          CntMax  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             cfg_err;
    logic             start;
    logic             stop;
    logic             x_valid;
    logic             x;
    logic             z;
    logic             busy;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             timeout;

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .PAT_W   (PAT_W),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W),
        .TMO_CYC (TMO_CYC)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_err     (cfg_err),
        .start       (start),
        .stop        (stop),
        .x_valid     (x_valid),
        .x           (x),
        .z           (z),
        .busy        (busy),
        .match_cnt   (match_cnt),
        .cnt_sat     (cnt_sat),
        .timeout     (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_z      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 armed, 2 run; received bits kept as a queue.
    int               m_state;
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    bit               m_hist[$];
    int               m_cnt;
    bit               m_sat;
    int               m_idle;
    bit               e_z;
    bit               e_err;
    bit               e_tmo;

    function automatic bit tail_matches();
        if (m_hist.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_update();
        e_z   = 1'b0;
        e_err = 1'b0;
        e_tmo = 1'b0;
        if (reset) begin
            m_state = 0; m_pat = '0; m_len = 0; m_ovl = 1'b0;
            m_hist.delete(); m_cnt = 0; m_sat = 1'b0; m_idle = 0;
        end else if (cfg_valid && m_state != 2) begin
            if (int'(cfg_len) >= 1 && int'(cfg_len) <= int'(PAT_W)) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
                m_cnt = 0; m_sat = 1'b0; m_state = 1;
            end else begin
                e_err = 1'b1;
            end
        end else if (m_state == 1 && start) begin
            m_hist.delete(); m_cnt = 0; m_sat = 1'b0; m_idle = 0; m_state = 2;
        end else if (m_state == 2) begin
            if (stop) begin
                m_state = 1;
            end else if (x_valid) begin
                m_idle = 0;
                m_hist.push_back(x);
                if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
                if (tail_matches()) begin
                    e_z = 1'b1;
                    if (m_cnt < CntMax) m_cnt++;
                    if (m_cnt == CntMax) m_sat = 1'b1;
                    if (!m_ovl) m_hist.delete();
                end
            end
`ifdef SEQ_DET_TIMEOUT_EN
            else begin
                m_idle++;
                if (m_idle == int'(TMO_CYC)) begin
                    e_tmo = 1'b1; m_state = 1; m_idle = 0;
                end
            end
`endif
        end
    endtask

    // One clock: model consumes the driven inputs, then all outputs are compared after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        if (z === 1'b1) n_z++;
        check_eq("cfg_ready", 32'(cfg_ready), 32'(m_state != 2));
        check_eq("busy", 32'(busy), 32'(m_state == 2));
        check_eq("z", 32'(z), 32'(e_z));
        check_eq("cfg_err", 32'(cfg_err), 32'(e_err));
        check_eq("match_cnt", 32'(match_cnt), 32'(m_cnt));
        check_eq("cnt_sat", 32'(cnt_sat), 32'(m_sat));
        check_eq("timeout", 32'(timeout), 32'(e_tmo));
    endtask

    task automatic idle_inputs();
        reset = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; start = 1'b0; stop = 1'b0; x_valid = 1'b0; x = 1'b0;
    endtask

    task automatic send_cfg(input logic [PAT_W-1:0] pat, input int len, input bit ovl);
        idle_inputs();
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
        step();
    endtask

    task automatic do_start();
        idle_inputs(); start = 1'b1; step();
    endtask

    task automatic do_stop();
        idle_inputs(); stop = 1'b1; step();
    endtask

    task automatic sample(input bit b, input bit with_stop);
        idle_inputs(); x_valid = 1'b1; x = b; stop = with_stop; step();
    endtask

    task automatic send_stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) sample(bits[i], 1'b0);
    endtask

    initial begin
        idle_inputs();
        // 1. reset
        reset = 1'b1; step(); step();
        idle_inputs(); step();

        // 2. overlapping 1011 on 1011011
        send_cfg(PAT_W'(4'b1011), 4, 1'b1);
        do_start();
        n_z = 0;
        send_stream(16'b1011011, 7);
        check_eq("t2_zcount", 32'(n_z), 32'd2);
        check_eq("t2_cnt", 32'(match_cnt), 32'd2);
        do_stop();

        // 3. same stream, non-overlapping
        send_cfg(PAT_W'(4'b1011), 4, 1'b0);
        do_start();
        n_z = 0;
        send_stream(16'b1011011, 7);
        check_eq("t3_zcount", 32'(n_z), 32'd1);
        check_eq("t3_cnt", 32'(match_cnt), 32'd1);
        do_stop();

        // 4. illegal lengths leave state and prior config alone
        send_cfg(PAT_W'(8'hFF), 0, 1'b1);
        check_eq("t4_err0", 32'(cfg_err), 32'd1);
        send_cfg(PAT_W'(8'hFF), PAT_W + 1, 1'b1);
        check_eq("t4_err9", 32'(cfg_err), 32'd1);
        check_eq("t4_cnt_kept", 32'(match_cnt), 32'd1);
        do_start();
        n_z = 0;
        send_stream(16'b1011, 4);
        check_eq("t4_old_cfg", 32'(n_z), 32'd1);
        do_stop();

        // 5. saturation of the 2-bit counter
        send_cfg(PAT_W'(1), 1, 1'b1);
        do_start();
        send_stream(16'b11111, 5);
        check_eq("t5_cnt_sat", 32'(match_cnt), 32'd3);
        check_eq("t5_sat", 32'(cnt_sat), 32'd1);
        do_stop();
        do_start();
        check_eq("t5_cnt_clr", 32'(match_cnt), 32'd0);
        check_eq("t5_sat_clr", 32'(cnt_sat), 32'd0);
        do_stop();

        // 6. stop coincident with the completing sample
        send_cfg(PAT_W'(4'b1011), 4, 1'b1);
        do_start();
        send_stream(16'b101, 3);
        sample(1'b1, 1'b1);
        check_eq("t6_no_z", 32'(z), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);

        // Idle stretch in RUN: times out only when the feature is built in.
        do_start();
        idle_inputs();
        for (int i = 0; i < 12; i++) step();
`ifdef SEQ_DET_TIMEOUT_EN
        check_eq("t6_tmo_busy", 32'(busy), 32'd0);
`else
        check_eq("t6_no_tmo_busy", 32'(busy), 32'd1);
`endif
        do_stop();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            idle_inputs();
            reset       = ($urandom_range(0, 299) == 0);
            cfg_valid   = ($urandom_range(0, 19) == 0);
            cfg_pattern = PAT_W'($urandom);
            cfg_len     = LEN_W'($urandom_range(0, 9));
            cfg_overlap = 1'($urandom_range(0, 1));
            start       = ($urandom_range(0, 9) == 0);
            stop        = ($urandom_range(0, 39) == 0);
            x_valid     = ($urandom_range(0, 3) != 0);
            x           = 1'($urandom_range(0, 1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
